pc_reg: RTL and testbench
=========================

Name: pc_reg

Overview:
- Program-counter register of the RV32I 5-stage pipeline fetch stage.
- Holds the address of the instruction being fetched.
- Loads the next-PC value from the fetch-stage next-PC mux when write-enabled, and holds its value when the hazard unit stalls fetch (pc_write=0).
- Also provides the sequential PC+4 and an instruction-address-misaligned flag for downstream fetch and exception logic.

Parameters:
- XLEN, 32, address/data width of the PC in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC on reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_write  input  1  PC load enable; 1 = load pc_next, 0 = stall (hold).
- pc_next  input  XLEN  next PC value from the next-PC mux (PC+4, branch or jump target).
- pc_out  output  XLEN  current PC, registered.
- pc_plus4  output  XLEN  combinational pc_out + 4, modulo 2^XLEN.
- pc_misaligned  output  1  combinational; 1 when pc_out[1:0] != 2'b00.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high on rst.
- Reset:
  - When rst=1, pc_out = RESET_VECTOR immediately, with no clock edge required, and it stays there while rst is held.
  - Consequently pc_plus4 = RESET_VECTOR+4 and pc_misaligned = 0.
- Reset release: the first rising clk edge with rst=0 is evaluated normally (load or hold per pc_write).
- Rising clk edge, rst=0:
  - pc_write=1: pc_out <= pc_next. Latency is one cycle; the new value is visible right after the edge.
  - pc_write=0: pc_out keeps its value. pc_next is ignored, and pc_plus4 and pc_misaligned hold too.
- pc_write and pc_next are sampled only at the rising edge. Changes between edges have no effect on pc_out.
- Reset mid-operation: asserting rst at any time overrides pc_write and pc_next. pc_out goes to RESET_VECTOR asynchronously.
- Width and alignment:
  - pc_next is stored verbatim; bits [1:0] are not forced to zero.
  - A misaligned target is reported through pc_misaligned; trapping is the job of downstream logic.
- pc_plus4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no carry out.
- Only pc_out is stateful. pc_plus4 and pc_misaligned are pure functions of pc_out, so they carry no glitches from pc_next.
- No X propagation from reset: every output is defined from reset onward.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN = 32
  - RESET_VECTOR default
  - INSTR_BYTES = 4, the increment used by pc_plus4
- No sub-module. The register, the incrementer and the alignment check live in pc_reg.
- The next-PC mux stays outside this block, in the fetch stage.

Test Plan:
- Reset: rst=1, pc_write=0, pc_next=0 from t=0, toggle clk -> pc_out=0x00000000, pc_plus4=0x00000004, pc_misaligned=0 throughout.
- Load after release: at t=12 set rst=0, pc_write=1, pc_next=0x4 -> pc_out=0x4 after edge t=15. Set pc_next=0x8 -> pc_out=0x8 after edge t=25.
- Stall: at t=32 set pc_write=0, pc_next=0xC -> pc_out stays 0x8 after edge t=35. Set pc_write=1 at t=42 -> pc_out=0xC after edge t=45.
- Async reset mid-run: with pc_out=0xC, pulse rst=1 between clock edges -> pc_out=RESET_VECTOR immediately, before the next edge. Value holds while rst=1 even with pc_write=1, pc_next=0x100.
- Misalignment and wrap:
  - pc_next=0x00000006, pc_write=1 -> after edge pc_out=0x6, pc_misaligned=1.
  - pc_next=0xFFFFFFFC -> pc_plus4=0x00000000, pc_misaligned=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline constants and small helpers used by the fetch-stage
// program-counter register.
package rv32_pkg;

  // Architectural register and address width.
  localparam int XLEN = 32;

  // Default address the PC is forced to while reset is asserted.
  // Any override must be 4-byte aligned.
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Size of one RV32I instruction. This is the step used for the sequential PC.
  localparam int INSTR_BYTES = 4;

  // An instruction address is misaligned when either of its two low bits is set.
  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register for the fetch stage. It holds the address being
// fetched, loads the next-PC mux output when pc_write is set, and holds when
// the hazard unit stalls fetch. It also provides the sequential PC+4 and a
// misalignment flag.
module pc_reg
  import rv32_pkg::*;
#(
  parameter int              XLEN_P       = XLEN,
  parameter logic [XLEN_P-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic [XLEN_P-1:0] pc_next,
  output logic [XLEN_P-1:0] pc_out,
  output logic [XLEN_P-1:0] pc_plus4,
  output logic              pc_misaligned
);

  // PC state: reset wins asynchronously; otherwise load on pc_write, else hold.
  // pc_next is stored verbatim. A misaligned target is only flagged here, and
  // downstream exception logic decides whether to trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out <= RESET_VECTOR;
    end else if (pc_write) begin
      pc_out <= pc_next;
    end
  end

  // Derived outputs depend only on the registered PC, so they stall along with
  // it and never see glitches on pc_next. The add wraps modulo 2^XLEN.
  always_comb begin
    pc_plus4      = pc_out + XLEN_P'(INSTR_BYTES);
    pc_misaligned = addr_misaligned(pc_out[1:0]);
  end

endmodule

// File: tb/tb_pc_reg.sv
module tb_pc_reg;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic [31:0] pc_next;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        pc_misaligned;

  int checks   = 0;
  int failures = 0;

  // Reference: the PC value the architecture says should be held right now.
  logic [31:0] exp_pc;

  pc_reg #(.XLEN_P(32), .RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .pc_next      (pc_next),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .pc_misaligned(pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {pc_out, pc_plus4, pc_misaligned} for a given architectural PC.
  function automatic logic [64:0] model_outputs(input logic [31:0] pc);
    logic [32:0] wide_sum;
    logic [31:0] next_seq;
    logic        mis;
    wide_sum = {1'b0, pc} + 33'd4;
    next_seq = wide_sum[31:0];
    mis      = ((pc % 4) != 0);
    return {pc, next_seq, mis};
  endfunction

  task automatic test_reset();
    // Before any clock edge: reset must already be applied.
    #1;
    exp_pc = RV;
    checks++;
    if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
      failures++;
      $display("FAIL reset_no_edge: got pc=%h p4=%h mis=%b want %h", pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
    end
    pc_write = 1'b1;
    pc_next  = 32'h0000_0040;
    @(posedge clk); #1;
    checks++;
    if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
      failures++;
      $display("FAIL reset_held_edge: got pc=%h p4=%h mis=%b want %h", pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
    end
  endtask

  task automatic test_load();
    // Release at t=12 with a load pending; the first edge loads normally.
    #6;
    rst      = 1'b0;
    pc_write = 1'b1;
    pc_next  = 32'h0000_0004;
    @(posedge clk); #1;
    exp_pc = 32'h0000_0004;
    checks++;
    if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
      failures++;
      $display("FAIL load_first: got pc=%h p4=%h mis=%b want %h", pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
    end
    pc_next = 32'h0000_0008;
    @(posedge clk); #1;
    exp_pc = 32'h0000_0008;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL load_second: got %h want %h", pc_out, exp_pc);
    end
  endtask

  task automatic test_stall();
    #6;
    pc_write = 1'b0;
    pc_next  = 32'h0000_000C;
    @(posedge clk); #1;
    checks++;
    if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
      failures++;
      $display("FAIL stall_hold: got pc=%h p4=%h mis=%b want %h", pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
    end
    #6;
    pc_write = 1'b1;
    @(posedge clk); #1;
    exp_pc = 32'h0000_000C;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL stall_release: got %h want %h", pc_out, exp_pc);
    end
  endtask

  task automatic test_edge_sampling();
    // Changes between edges must not reach pc_out.
    pc_write = 1'b1;
    pc_next  = 32'h0000_0123;
    #3;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL mid_cycle_change: got %h want %h", pc_out, exp_pc);
    end
    pc_write = 1'b0;
    pc_next  = 32'h0000_0200;
    @(posedge clk); #1;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL late_change_hold: got %h want %h", pc_out, exp_pc);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst      = 1'b1;
    pc_write = 1'b1;
    pc_next  = 32'h0000_0100;
    #1;
    exp_pc = RV;
    checks++;
    if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
      failures++;
      $display("FAIL async_reset_immediate: got pc=%h p4=%h mis=%b want %h", pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
    end
    @(posedge clk); #1;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL async_reset_held: got %h want %h", pc_out, exp_pc);
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_pc = 32'h0000_0100;
    checks++;
    if (pc_out !== exp_pc) begin
      failures++;
      $display("FAIL release_first_edge: got %h want %h", pc_out, exp_pc);
    end
  endtask

  task automatic test_misaligned_wrap();
    logic [31:0] pattern [3];
    pattern[0] = 32'h0000_0006;
    pattern[1] = 32'hFFFF_FFFC;
    pattern[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #3;
      pc_write = 1'b1;
      pc_next  = pattern[i];
      @(posedge clk); #1;
      exp_pc = pattern[i];
      checks++;
      if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
        failures++;
        $display("FAIL misalign_wrap[%0d]: got pc=%h p4=%h mis=%b want %h", i, pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      // Nothing may have moved since the last edge, even with inputs toggled.
      checks++;
      if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
        failures++;
        $display("FAIL rand_between[%0d]: got pc=%h p4=%h mis=%b want %h", i, pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
      end
      pc_write = 1'($urandom_range(0, 1));
      pc_next  = $urandom;
      if ($urandom_range(0, 1) == 0) pc_next[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        #1;
        exp_pc = RV;
        checks++;
        if (pc_out !== exp_pc) begin
          failures++;
          $display("FAIL rand_async_reset[%0d]: got %h want %h", i, pc_out, exp_pc);
        end
        rst = 1'b0;
      end
      @(posedge clk);
      if (pc_write) exp_pc = pc_next;
      #1;
      checks++;
      if ({pc_out, pc_plus4, pc_misaligned} !== model_outputs(exp_pc)) begin
        failures++;
        $display("FAIL rand_edge[%0d]: got pc=%h p4=%h mis=%b want %h", i, pc_out, pc_plus4, pc_misaligned, model_outputs(exp_pc));
      end
      // Disturb inputs mid-cycle. These values must not be captured.
      pc_next  = $urandom;
      pc_write = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst      = 1'b1;
    pc_write = 1'b0;
    pc_next  = 32'h0;
    exp_pc   = RV;
    test_reset();
    test_load();
    test_stall();
    test_edge_sampling();
    test_async_reset();
    test_misaligned_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
